// File: rtl/tt_logic_seq_pkg.sv
// Shared definitions for the tt_um_logic_seq operand sequencer.
// Contents: FSM state enum, op-code constants and the default operand width.
package tt_logic_seq_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   localparam logic [1:0] OP_XOR = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;

   typedef enum logic [1:0] {
      StLoadA,
      StLoadB,
      StExec,
      StDone
   } state_e;

endpackage

// File: rtl/logic_seq_alu.sv
// Combinational WIDTH-bit op unit for tt_um_logic_seq.
// Ports:
//   a_i, b_i  operands
//   op_i      op code (OP_XOR / OP_AND / OP_OR / OP_ADD)
//   result_o  WIDTH-bit result (ADD wraps modulo 2^WIDTH)
//   carry_o   carry out of ADD, 0 for the logic ops
module logic_seq_alu
   import tt_logic_seq_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [1:0]       op_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o
);

   logic [WIDTH:0] sum;

   assign sum = {1'b0, a_i} + {1'b0, b_i};

   always_comb begin
      result_o = '0;
      carry_o  = 1'b0;
      case (op_i)
         OP_XOR: result_o = a_i ^ b_i;
         OP_AND: result_o = a_i & b_i;
         OP_OR:  result_o = a_i | b_i;
         OP_ADD: begin
            result_o = sum[WIDTH-1:0];
            carry_o  = sum[WIDTH];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/tt_um_logic_seq.sv
// Two-operand load/execute sequencer: loads A then B over ui_in using a
// valid/ready handshake, executes one op, and shows the registered result.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ena               enable; low freezes all state and outputs
//   VGND, VPWR        power pins, no logic function
//   ui_in             operand bus, bits [WIDTH-1:0] used
//   uio_in            [0] valid, [2:1] op, [3] acc (accumulate builds only)
//   uo_out            result, zero-extended to 8 bits
//   uio_out           [4] ready, [5] done, [6] carry, [7] parity, [3:0] zero
//   uio_oe            constant 8'hF0
//   ua                analog pins, unconnected
// Build option: LOGIC_SEQ_ACCUM_EN adds accumulate mode (acc=1 at A accept
// skips LOAD_B and computes op(previous result, A)).
module tt_um_logic_seq
   import tt_logic_seq_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic       VGND,
   input  logic       VPWR,
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   inout  wire  [7:0] ua
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               carry_q, carry_d;
   logic               parity_q, parity_d;

   logic               valid;
   logic [1:0]         op_in;
   logic [WIDTH-1:0]   operand;
   logic               ready;
   logic               done;
   logic               accept;
   logic [WIDTH-1:0]   alu_x, alu_y, alu_res;
   logic               alu_carry;
   logic               unused_pins;

   assign valid   = uio_in[0];
   assign op_in   = uio_in[2:1];
   assign operand = ui_in[WIDTH-1:0];

   assign ready  = (state_q == StLoadA) || (state_q == StLoadB);
   assign done   = (state_q == StDone);
   assign accept = ena && valid && ready;

   // Whole buses folded in so the ignored bits and power pins are accounted for.
   assign unused_pins = ^{VGND, VPWR, ui_in, uio_in, ua};

`ifdef LOGIC_SEQ_ACCUM_EN
   logic acc_q, acc_d;

   // Accumulate pass: previous result is the left operand, A the right.
   assign alu_x = acc_q ? result_q : a_q;
   assign alu_y = acc_q ? a_q : b_q;
`else
   assign alu_x = a_q;
   assign alu_y = b_q;
`endif

   logic_seq_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a_i      (alu_x),
      .b_i      (alu_y),
      .op_i     (op_q),
      .result_o (alu_res),
      .carry_o  (alu_carry)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      carry_d  = carry_q;
      parity_d = parity_q;
`ifdef LOGIC_SEQ_ACCUM_EN
      acc_d    = acc_q;
`endif
      if (ena) begin
         case (state_q)
            StLoadA: begin
               if (accept) begin
                  a_d = operand;
`ifdef LOGIC_SEQ_ACCUM_EN
                  if (uio_in[3]) begin
                     acc_d   = 1'b1;
                     op_d    = op_in;
                     state_d = StExec;
                  end else begin
                     acc_d   = 1'b0;
                     state_d = StLoadB;
                  end
`else
                  state_d = StLoadB;
`endif
               end
            end
            StLoadB: begin
               if (accept) begin
                  b_d     = operand;
                  op_d    = op_in;
                  state_d = StExec;
               end
            end
            StExec: begin
               result_d = alu_res;
               carry_d  = alu_carry;
               parity_d = ^alu_res;
               state_d  = StDone;
            end
            StDone:  state_d = StLoadA;
            default: state_d = StLoadA;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StLoadA;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_XOR;
         result_q <= '0;
         carry_q  <= 1'b0;
         parity_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         parity_q <= parity_d;
      end
   end

`ifdef LOGIC_SEQ_ACCUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
      end
   end
`endif

   assign uo_out  = 8'(result_q);
   assign uio_out = {parity_q, carry_q, done, ready, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule
